// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access codes, FSM
// encoding, counter width, the latched command payload and the access
// legality check.
package dmem_pkg;

    localparam int unsigned WAIT_W = 4;

    // Load codes carried on mem_read
    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LB   = 3'b001,
        RD_LH   = 3'b010,
        RD_LW   = 3'b011,
        RD_LBU  = 3'b100,
        RD_LHU  = 3'b101,
        RD_ILL6 = 3'b110,
        RD_ILL7 = 3'b111
    } rd_code_e;

    // Store codes carried on mem_write
    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_SB   = 2'b01,
        WR_SH   = 2'b10,
        WR_SW   = 2'b11
    } wr_code_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_ST = 2'b01,
        RESP    = 2'b10
    } state_e;

    // Command latched on acceptance (address width is a module parameter)
    typedef struct packed {
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] wdata;
    } req_cmd_t;

    // Illegal code, load+store together, or misaligned half/word access
    function automatic logic access_err(input logic [2:0] rd,
                                        input logic [1:0] wr,
                                        input logic [1:0] off);
        logic is_half;
        logic is_word;
        is_half = (rd == RD_LH) || (rd == RD_LHU) || (wr == WR_SH);
        is_word = (rd == RD_LW) || (wr == WR_SW);
        return (rd == RD_ILL6) || (rd == RD_ILL7)
            || ((rd != RD_NONE) && (wr != WR_NONE))
            || (is_half && off[0])
            || (is_word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// load_extend: selects the addressed byte/half lane of a 32-bit little-endian
// word and sign- or zero-extends it according to the load code.
//   word_i     : aligned 32-bit word containing the access
//   off_i      : byte offset within the word (addr[1:0])
//   mem_read_i : load code
//   data_o     : extended load result (0 for none/illegal codes)
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  mem_read_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane selection; half accesses are aligned so only off_i[1] matters
    always_comb begin
        byte_c = word_i[{off_i, 3'b000} +: 8];
        half_c = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension by load type
    always_comb begin
        data_o = '0;
        case (mem_read_i)
            RD_LB:   data_o = {{24{byte_c[7]}}, byte_c};
            RD_LH:   data_o = {{16{half_c[15]}}, half_c};
            RD_LW:   data_o = word_i;
            RD_LBU:  data_o = {24'h000000, byte_c};
            RD_LHU:  data_o = {16'h0000, half_c};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed little-endian data memory with a fixed
// number of wait states per access and a one-cycle response pulse.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   addr                : byte address
//   mem_read/mem_write  : load/store codes
//   wdata               : store data
//   resp_valid          : one-cycle response pulse
//   rdata, resp_err     : load result and error flag, held between responses
//   busy                : accepted request outstanding (pipeline stall)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_ADDR = 8,
    parameter int unsigned WAIT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MEM_ADDR-1:0] addr,
    input  logic [2:0]          mem_read,
    input  logic [1:0]          mem_write,
    input  logic [31:0]         wdata,
    output logic                resp_valid,
    output logic [31:0]         rdata,
    output logic                resp_err,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [MEM_ADDR-1:0] addr_q, addr_d;
    req_cmd_t            cmd_q, cmd_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [7:0]          mem_q [DEPTH];

    logic                accept_c;
    logic                enter_resp_c;
    logic [MEM_ADDR-1:0] cur_addr_c;
    req_cmd_t            cur_cmd_c;
    logic [MEM_ADDR-1:0] base_c;
    logic [31:0]         word_c;
    logic [31:0]         load_c;
    logic                err_c;
    logic [3:0]          we_c;
    logic [31:0]         wlane_c;

    assign accept_c = req_valid && (state_q == IDLE)
                   && ((mem_read != 3'b000) || (mem_write != 2'b00));

    // With WAIT=0 the access completes on the accept edge itself, so the
    // live inputs are used in IDLE and the latched copy afterwards.
    always_comb begin
        cur_addr_c = addr_q;
        cur_cmd_c  = cmd_q;
        if (state_q == IDLE) begin
            cur_addr_c      = addr;
            cur_cmd_c.rd    = mem_read;
            cur_cmd_c.wr    = mem_write;
            cur_cmd_c.wdata = wdata;
        end
    end

    // Gather the aligned word around the access
    always_comb begin
        base_c = {cur_addr_c[MEM_ADDR-1:2], 2'b00};
        word_c = '0;
        for (int i = 0; i < 4; i++) begin
            word_c[8*i +: 8] = mem_q[base_c | MEM_ADDR'(i)];
        end
    end

    load_extend u_load_extend (
        .word_i     (word_c),
        .off_i      (cur_addr_c[1:0]),
        .mem_read_i (cur_cmd_c.rd),
        .data_o     (load_c)
    );

    assign err_c = access_err(cur_cmd_c.rd, cur_cmd_c.wr, cur_addr_c[1:0]);

    // Next state, counter, request latch and response capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d       = addr;
                    cmd_d.rd     = mem_read;
                    cmd_d.wr     = mem_write;
                    cmd_d.wdata  = wdata;
                    if (WAIT == 0) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT_ST;
                        cnt_d   = WAIT_W'(WAIT - 1);
                    end
                end
            end
            WAIT_ST: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp_c) begin
            err_d   = err_c;
            rdata_d = (err_c || (cur_cmd_c.wr != WR_NONE)) ? 32'h0 : load_c;
        end
    end

    // Store byte enables and lane-aligned data; nothing is written on error
    always_comb begin
        we_c    = 4'b0000;
        wlane_c = cur_cmd_c.wdata << {cur_addr_c[1:0], 3'b000};
        if (enter_resp_c && !err_c) begin
            case (cur_cmd_c.wr)
                WR_SB:   we_c = 4'b0001 << cur_addr_c[1:0];
                WR_SH:   we_c = 4'b0011 << cur_addr_c[1:0];
                WR_SW:   we_c = 4'b1111;
                default: we_c = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we_c[i]) begin
                    mem_q[base_c | MEM_ADDR'(i)] <= wlane_c[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign resp_err   = err_q;
    assign busy       = ((state_q == WAIT_ST) || accept_c) && !rst;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0;
    logic        req_valid;
    logic [7:0]  addr;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] wdata;
    logic        sel;

    logic        ready2, rvalid2, err2, busy2;
    logic [31:0] rdata2;
    logic        ready0, rvalid0, err0, busy0;
    logic [31:0] rdata0;

    logic        s_ready, s_rvalid, s_err, s_busy;
    logic [31:0] s_rdata;

    int checks = 0;
    int errors = 0;

    // Reference memories: [0] for WAIT=2 instance, [1] for WAIT=0 instance
    logic [7:0] mdl [2][256];

    always #5 clk = ~clk;

    dmem_responder #(.MEM_ADDR(8), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid && !sel), .req_ready(ready2),
        .addr(addr), .mem_read(mem_read), .mem_write(mem_write), .wdata(wdata),
        .resp_valid(rvalid2), .rdata(rdata2), .resp_err(err2), .busy(busy2)
    );

    dmem_responder #(.MEM_ADDR(8), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid && sel), .req_ready(ready0),
        .addr(addr), .mem_read(mem_read), .mem_write(mem_write), .wdata(wdata),
        .resp_valid(rvalid0), .rdata(rdata0), .resp_err(err0), .busy(busy0)
    );

    assign s_ready  = sel ? ready0  : ready2;
    assign s_rvalid = sel ? rvalid0 : rvalid2;
    assign s_err    = sel ? err0    : err2;
    assign s_busy   = sel ? busy0   : busy2;
    assign s_rdata  = sel ? rdata0  : rdata2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory model: legality, load extension, store commit
    task automatic model(input int s, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [7:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] d);
        int   ai;
        logic mis;
        logic [7:0] b0, b1, b2, b3;
        ai  = int'(a);
        mis = (((rd == 3'd2) || (rd == 3'd5) || (wr == 2'd2)) && a[0])
           || (((rd == 3'd3) || (wr == 2'd3)) && (a[1:0] != 2'b00));
        e   = (rd >= 3'd6) || ((rd != 3'd0) && (wr != 2'd0)) || mis;
        d   = 32'h0;
        if (!e) begin
            if (wr == 2'd1) begin
                mdl[s][ai] = wd[7:0];
            end else if (wr == 2'd2) begin
                mdl[s][ai]   = wd[7:0];
                mdl[s][ai+1] = wd[15:8];
            end else if (wr == 2'd3) begin
                for (int k = 0; k < 4; k++) mdl[s][ai+k] = wd[8*k +: 8];
            end else begin
                b0 = mdl[s][ai];
                b1 = (ai + 1 < 256) ? mdl[s][ai+1] : 8'h00;
                b2 = (ai + 2 < 256) ? mdl[s][ai+2] : 8'h00;
                b3 = (ai + 3 < 256) ? mdl[s][ai+3] : 8'h00;
                case (rd)
                    3'd1: d = {{24{b0[7]}}, b0};
                    3'd2: d = {{16{b1[7]}}, b1, b0};
                    3'd3: d = {b3, b2, b1, b0};
                    3'd4: d = {24'h0, b0};
                    3'd5: d = {16'h0, b1, b0};
                    default: d = 32'h0;
                endcase
            end
        end
    endtask

    // One request/response; entered and left at a negedge
    task automatic txn(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                       input logic [7:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] d;
        int          n;
        int          lat;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check({tag, " ready_timeout"}, 32'(s_ready), 32'd1);
        req_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; wdata = wd;
        model(int'(sel), rd, wr, a, wd, e, d);
        #1;
        check({tag, " busy_accept"}, 32'(s_busy), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_read = 3'd0; mem_write = 2'd0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_rvalid && lat < 40);
        check({tag, " latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
        check({tag, " err"}, 32'(s_err), 32'(e));
        check({tag, " rdata"}, s_rdata, d);
        check({tag, " ready_resp"}, 32'(s_ready), 32'd0);
        check({tag, " busy_resp"}, 32'(s_busy), 32'd0);
        @(negedge clk);
        check({tag, " pulse_end"}, 32'(s_rvalid), 32'd0);
        check({tag, " rdata_hold"}, s_rdata, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d;
        logic [2:0]  rrd;
        logic [1:0]  rwr;
        logic [7:0]  ra;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) mdl[s][i] = 8'h00;
        sel = 1'b0; req_valid = 1'b0; addr = '0; mem_read = '0; mem_write = '0; wdata = '0;
        rst2 = 1'b1; rst0 = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst rvalid", 32'(s_rvalid), 32'd0);
            check("rst rdata", s_rdata, 32'h0);
            check("rst err", 32'(s_err), 32'd0);
            check("rst busy", 32'(s_busy), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst2 = 1'b0; rst0 = 1'b0;
        #1;
        check("post_rst ready2", 32'(ready2), 32'd1);
        check("post_rst ready0", 32'(ready0), 32'd1);
        @(negedge clk);

        // WAIT=2 directed sequence
        txn("sw10", 3'd0, 2'd3, 8'h10, 32'hDEADBEEF);
        txn("lw10", 3'd3, 2'd0, 8'h10, 32'h0);
        check("lw10 const", s_rdata, 32'hDEADBEEF);
        txn("lb13", 3'd1, 2'd0, 8'h13, 32'h0);
        check("lb13 const", s_rdata, 32'hFFFFFFDE);
        txn("lbu13", 3'd4, 2'd0, 8'h13, 32'h0);
        check("lbu13 const", s_rdata, 32'h000000DE);
        txn("lh10", 3'd2, 2'd0, 8'h10, 32'h0);
        check("lh10 const", s_rdata, 32'hFFFFBEEF);
        txn("lhu12", 3'd5, 2'd0, 8'h12, 32'h0);
        check("lhu12 const", s_rdata, 32'h0000DEAD);
        txn("lw11_mis", 3'd3, 2'd0, 8'h11, 32'h0);
        check("lw11 err", 32'(s_err), 32'd1);
        txn("sh21_mis", 3'd0, 2'd2, 8'h21, 32'hA5A5A5A5);
        check("sh21 err", 32'(s_err), 32'd1);
        txn("rd110", 3'd6, 2'd0, 8'h20, 32'h0);
        check("rd110 err", 32'(s_err), 32'd1);
        txn("lb_sb", 3'd1, 2'd1, 8'h20, 32'h77777777);
        check("lb_sb err", 32'(s_err), 32'd1);
        txn("lw20", 3'd3, 2'd0, 8'h20, 32'h0);
        check("lw20 const", s_rdata, 32'h0);

        // Request with no codes is ignored
        req_valid = 1'b1; mem_read = 3'd0; mem_write = 2'd0; addr = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nop ready", 32'(s_ready), 32'd1);
            check("nop busy", 32'(s_busy), 32'd0);
            check("nop rvalid", 32'(s_rvalid), 32'd0);
        end
        req_valid = 1'b0;

        // Reset during WAIT_ST aborts the store
        req_valid = 1'b1; addr = 8'h40; mem_read = 3'd0; mem_write = 2'd3; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_write = 2'd0;
        @(negedge clk);
        check("abort busy_wait", 32'(s_busy), 32'd1);
        rst2 = 1'b1;
        #1;
        check("abort rst_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 256; i++) mdl[0][i] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort no_resp", 32'(s_rvalid), 32'd0);
        end
        txn("lw40", 3'd3, 2'd0, 8'h40, 32'h0);
        check("lw40 const", s_rdata, 32'h0);

        // WAIT=0 directed sequence
        sel = 1'b1;
        @(negedge clk);
        txn("sbff", 3'd0, 2'd1, 8'hFF, 32'h1234565A);
        txn("lbuff", 3'd4, 2'd0, 8'hFF, 32'h0);
        check("lbuff const", s_rdata, 32'h0000005A);

        // Request held across RESP is taken in the following IDLE cycle
        req_valid = 1'b1; addr = 8'h80; mem_read = 3'd0; mem_write = 2'd3; wdata = 32'hCAFEF00D;
        model(1, 3'd0, 2'd3, 8'h80, 32'hCAFEF00D, e, d);
        @(posedge clk);
        #1;
        mem_read = 3'd3; mem_write = 2'd0;
        @(negedge clk);
        check("hold resp1", 32'(s_rvalid), 32'd1);
        check("hold ready_resp", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("hold idle_ready", 32'(s_ready), 32'd1);
        check("hold idle_busy", 32'(s_busy), 32'd1);
        model(1, 3'd3, 2'd0, 8'h80, 32'h0, e, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_read = 3'd0;
        @(negedge clk);
        check("hold resp2", 32'(s_rvalid), 32'd1);
        check("hold rdata", s_rdata, d);
        @(negedge clk);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int i = 0; i < 80; i++) begin
                rrd = 3'($urandom_range(0, 7));
                rwr = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 0) rwr = 2'd0;
                    else rrd = 3'd0;
                end
                if (rrd == 3'd0 && rwr == 2'd0) rrd = 3'd3;
                ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                 : 8'($urandom_range(0, 255));
                txn("rand", rrd, rwr, ra, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
